// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant held while the owner keeps requesting.
// Define RR_HOLD_LIMIT_EN to force a release after MAX_HOLD consecutive grant cycles.
module rr_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8,
  localparam int unsigned IdW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IdW-1:0] gnt_id,
  output logic           busy
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e         state_q;
  logic [IdW-1:0] ptr_q;
  logic [IdW-1:0] rel_ptr;
  logic [IdW-1:0] arb_base;
  logic [IdW-1:0] arb_idx;
  logic           arb_found;
  logic           hold_expired;
  logic           release_evt;

`ifdef RR_HOLD_LIMIT_EN
  localparam int unsigned CntW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  // Counts grant cycles already shown minus one; 0 on the first cycle of a grant.
  logic [CntW-1:0] hold_cnt_q;

  assign hold_expired = (hold_cnt_q == CntW'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
    end else if (state_q == StIdle || release_evt) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_q + CntW'(1);
    end
  end
`else
  assign hold_expired = 1'b0;
`endif

  always_comb begin
    rel_ptr = (gnt_id == IdW'(N - 1)) ? '0 : gnt_id + IdW'(1);
  end

  always_comb begin
    release_evt = (state_q == StGrant) && (!req[gnt_id] || hold_expired);
  end

  // On release the search starts just past the outgoing owner, which leaves it lowest priority.
  always_comb begin
    arb_base = (state_q == StGrant) ? rel_ptr : ptr_q;
  end

  always_comb begin
    int unsigned idx;
    idx       = 0;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(arb_base) + i;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!arb_found && req[IdW'(idx)]) begin
        arb_found = 1'b1;
        arb_idx   = IdW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (arb_found) begin
            gnt     <= {{(N-1){1'b0}}, 1'b1} << arb_idx;
            gnt_id  <= arb_idx;
            busy    <= 1'b1;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          if (release_evt) begin
            ptr_q <= rel_ptr;
            if (arb_found) begin
              gnt    <= {{(N-1){1'b0}}, 1'b1} << arb_idx;
              gnt_id <= arb_idx;
            end else begin
              gnt     <= '0;
              busy    <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          gnt     <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: a rotating-priority reference model queues expected
// outputs per clock; a monitor on the falling edge pops and compares them.
module tb_rr_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
`ifdef RR_HOLD_LIMIT_EN
  localparam bit HoldEn = 1'b1;
`else
  localparam bit HoldEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         busy;

  rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         busy;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: owner index (-1 when idle), rotating start point, cycles held.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  int m_last  = 0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endfunction

  function automatic int pick(logic [N-1:0] r, int from);
    for (int k = 0; k < N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  function automatic void model_step(logic [N-1:0] r, logic rs);
    exp_t e;
    if (rs) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
      m_last  = 0;
    end else if (m_owner < 0) begin
      m_owner = pick(r, m_ptr);
      if (m_owner >= 0) begin
        m_held = 1;
        m_last = m_owner;
      end
    end else if (!r[m_owner] || (HoldEn && m_held >= MAX_HOLD)) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = pick(r, m_ptr);
      m_held  = 1;
      if (m_owner >= 0) m_last = m_owner;
    end else begin
      m_held++;
    end
    e.gnt    = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    e.gnt_id = 2'(m_last);
    e.busy   = (m_owner >= 0);
    sb.push_back(e);
  endfunction

  // Drive inputs for one clock, then record the expected post-edge outputs.
  task automatic cycle(logic [N-1:0] r, logic rs = 1'b0);
    req = r;
    rst = rs;
    @(posedge clk);
    model_step(r, rs);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("gnt", 32'(gnt), 32'(mon_e.gnt));
      check("busy", 32'(busy), 32'(mon_e.busy));
      check("gnt_id", 32'(gnt_id), 32'(mon_e.gnt_id));
      check("onehot0", 32'($onehot0(gnt)), 32'd1);
      check("busy_or", 32'(busy), 32'(|gnt));
    end
  end

  initial begin
    logic [N-1:0] r;
    // Reset with all requesting, then first grant goes to requester 0
    cycle(4'b1111, 1'b1);
    cycle(4'b1111, 1'b1);
    check("rst_gnt", 32'(gnt), 32'h0);
    cycle(4'b1111);
    check("first_gnt", 32'(gnt), 32'h1);
    cycle(4'b0000);
    // Single requester
    cycle(4'b0100);
    check("single_gnt", 32'(gnt), 32'h4);
    cycle(4'b0100);
    cycle(4'b0100);
    cycle(4'b0000);
    check("single_rel", 32'(busy), 32'h0);
    // Rotation with brief drops after two grant cycles
    cycle(4'b0000, 1'b1);
    for (int i = 0; i < 14; i++) begin
      r = 4'b1111;
      if (m_owner >= 0 && m_held >= 2) r[m_owner] = 1'b0;
      cycle(r);
    end
    // Wrap from requester 3 and priority after release
    cycle(4'b0000);
    cycle(4'b1000);
    cycle(4'b1000);
    check("wrap_own3", 32'(gnt), 32'h8);
    cycle(4'b0000);
    cycle(4'b1010);
    check("wrap_gnt1", 32'(gnt), 32'h2);
    cycle(4'b1010);
    cycle(4'b0000);
    cycle(4'b1001);
    check("ptr2_gnt3", 32'(gnt), 32'h8);
    cycle(4'b0000);
    // Reset mid-grant restarts the pointer at 0
    cycle(4'b0100);
    cycle(4'b0100);
    cycle(4'b0110, 1'b1);
    check("midrst_gnt", 32'(gnt), 32'h0);
    cycle(4'b0110);
    check("midrst_after", 32'(gnt), 32'h2);
    cycle(4'b0000);
    // Hold limit with two persistent requesters
    cycle(4'b0000, 1'b1);
    for (int i = 0; i < 40; i++) begin
      cycle(4'b0011);
      if (i == 7) check("hold_8th", 32'(gnt), 32'h1);
      if (i == 8) check("hold_9th", 32'(gnt), HoldEn ? 32'h2 : 32'h1);
    end
    cycle(4'b0000);
    // Random traffic: mostly sticky requests with occasional flips and rare resets
    r = '0;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      end
      cycle(r, ($urandom_range(0, 63) == 0));
    end
    cycle(4'b0000);
    for (int w = 0; w < 5 && sb.size() > 0; w++) @(negedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
